// File: rtl/pdu_inbuf_arb.sv
// PDU input scheduler: round-robin arbiter over two instruction requesters feeding a DEPTH-entry FIFO.
// Latency: an accepted instruction is visible at to_pdubuf_dout one cycle after its push edge (no bypass).
// Backpressure: reqN_ready drops while the FIFO is full or in reset; PDU pops are ignored while reg_stall is high.
// Build option: define PDU_ARB_PRIO_EN for strict req0-over-req1 priority instead of round robin.

`ifndef TO_PDUBUF_BW
`define TO_PDUBUF_BW 64
`endif

module pdu_inbuf_arb #(
    parameter int DATA_BW = `TO_PDUBUF_BW,
    parameter int DEPTH   = 4,
    parameter int PTR_BW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [DATA_BW-1:0] req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [DATA_BW-1:0] req1_data,
    output logic               req1_ready,
    input  logic               reg_stall,
    input  logic               pdu_pop,
    output logic [DATA_BW-1:0] to_pdubuf_dout,
    output logic               to_pdubuf_empty,
    output logic [PTR_BW:0]    buf_count,
    output logic               buf_err
);

    localparam logic [PTR_BW:0] FULL_CNT = (PTR_BW+1)'(DEPTH);

    // Storage and control state
    logic [DATA_BW-1:0] mem_q [DEPTH];
    logic [PTR_BW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_BW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_BW:0]    count_q,  count_d;
    logic               last_grant_q, last_grant_d;
    logic               buf_err_q, buf_err_d;

    logic               full;
    logic               empty;
    logic               grant0;
    logic               grant1;
    logic               push;
    logic               pop;
    logic [DATA_BW-1:0] push_data;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Pick at most one requester; ties go to whoever did not win last time.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef PDU_ARB_PRIO_EN
        if (req0_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
`else
        if (req0_valid && req1_valid) begin
            if (last_grant_q) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
`endif
    end

    // Ready is held low while reset is asserted so nothing looks accepted during reset.
    assign req0_ready = grant0 & ~full & rst;
    assign req1_ready = grant1 & ~full & rst;

    assign push      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign push_data = req1_ready ? req1_data : req0_data;
    assign pop       = pdu_pop & ~reg_stall & ~empty;

    // Next-state for pointers, occupancy, round-robin history and the sticky error.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        buf_err_d    = buf_err_q;
        if (push) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            last_grant_d = req1_ready;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (pdu_pop && !reg_stall && empty) begin
            buf_err_d = 1'b1;
        end
    end

    // Control registers; reset discards any buffered entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            buf_err_q    <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            buf_err_q    <= buf_err_d;
        end
    end

    // Entry storage needs no reset: occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign to_pdubuf_dout  = empty ? '0 : mem_q[rd_ptr_q];
    assign to_pdubuf_empty = empty;
    assign buf_count       = count_q;
    assign buf_err         = buf_err_q;

endmodule

// File: doc/pdu_inbuf_arb.md
Name: pdu_inbuf_arb

Overview:
- Input-side scheduler for the PDU. Arbitrates between two instruction requesters (req0: main QID instruction stream; req1: auxiliary LQ-management stream).
- Accepted instructions are buffered in a small FIFO. The FIFO presents the to_pdubuf_dout/to_pdubuf_empty pair the PDU consumes.
- Honours the PDU pipeline stall, so a held PDU never loses or duplicates an instruction.

Parameters:
- DATA_BW, `TO_PDUBUF_BW, width of one packed PDU instruction {opcode, lqlist, lpplist, oplist, mreglist}.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PTR_BW, 2, log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an instruction.
- req0_data  in  DATA_BW  requester 0 instruction.
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready.
- req1_valid  in  1  requester 1 has an instruction.
- req1_data  in  DATA_BW  requester 1 instruction.
- req1_ready  out  1  requester 1 accepted this cycle when valid&ready.
- reg_stall  in  1  PDU register stall; blocks pops.
- pdu_pop  in  1  PDU takes the head entry (PDU take_in strobe).
- to_pdubuf_dout  out  DATA_BW  FIFO head entry.
- to_pdubuf_empty  out  1  FIFO empty.
- buf_count  out  PTR_BW+1  occupancy, 0..DEPTH.
- buf_err  out  1  sticky protocol error (pop while empty).

Behaviour:
- Reset (rst=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0, last_grant=1 (so req0 wins the first contention), buf_err=0.
  - Memory contents are don't-care.
  - Outputs during reset: to_pdubuf_empty=1, buf_count=0, req0_ready=0, req1_ready=0, to_pdubuf_dout=0 (output gated while empty).
  - Reset asserted mid-operation discards all buffered entries.
- Full flag: full = (count==DEPTH).
- Arbitration is combinational from valids, last_grant and full:
  - Only req0 valid -> grant0.
  - Only req1 valid -> grant1.
  - Both valid -> grant the requester != last_grant (round robin).
  - reqN_ready = grantN & ~full.
  - Exactly one push per cycle at most; ready is never asserted to a non-valid requester.
- Push = (req0_valid&req0_ready) | (req1_valid&req1_ready).
  - On push: mem[wr_ptr] <= granted data; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH; last_grant <= granted index.
  - last_grant changes only on an accepted push.
- Pop = pdu_pop & ~reg_stall & ~to_pdubuf_empty.
  - On pop: rd_ptr <= rd_ptr+1, modulo DEPTH.
  - pdu_pop while reg_stall=1 is ignored entirely: no pointer move, no error.
- count update:
  - push&~pop: +1.
  - pop&~push: -1.
  - push&pop: unchanged; the head is read and a new entry written in the same cycle.
- Full: ready stays low even if a pop occurs in the same cycle. There is no write-through on full; space is visible the next cycle.
- Empty: to_pdubuf_empty=1 and to_pdubuf_dout=0.
  - A pushed entry is visible at the head one cycle after the push edge. There is no same-cycle bypass.
- Head read: to_pdubuf_dout = mem[rd_ptr], combinational from registered storage. It is stable across stall cycles.
- Error: pdu_pop & ~reg_stall & to_pdubuf_empty sets buf_err=1. Only reset clears it. State is otherwise unchanged.
- Ordering:
  - Entries leave in acceptance order.
  - Per-requester order is preserved.
  - No requester waits more than one competing grant while the FIFO is not full.

Optional Feature:
- Macro: PDU_ARB_PRIO_EN.
- Defined: strict fixed priority.
  - req0 wins whenever req0_valid=1; req1 is granted only when req0_valid=0.
  - last_grant is still maintained but does not affect grants.
- Undefined: round robin as above.

Test Plan:
- Reset, then req0 pushes A=0x11 while pdu_pop=0 -> cycle after push: empty=0, dout=0x11, count=1. Then pop -> empty=1, dout=0, count=0.
- req0 and req1 both valid continuously with FIFO draining every cycle, starting from reset -> grant order 0,1,0,1. With PDU_ARB_PRIO_EN, only req0 is granted.
- DEPTH=4, push 0x1..0x4 with no pops -> count=4, both ready=0 while valid. Pop with req0 valid in the same cycle -> req0_ready stays 0 that cycle and is 1 the next; count 4->3->4.
- Fill 2 entries, hold pdu_pop=1 with reg_stall=1 for 3 cycles -> count stays 2, dout unchanged, buf_err=0. Release stall -> one pop per cycle, entries in order.
- Push and pop in the same cycle at count=2 -> count stays 2. Run 9 push/pop pairs -> pointers wrap past DEPTH, data order intact.
- pdu_pop=1, reg_stall=0 while empty -> buf_err=1 and stays 1 through later traffic. Async rst low mid-fill (count=3) -> immediately count=0, empty=1, buf_err=0.
